id_issue: RTL

ID_ISSUE -- requirements
Module: id_issue

---
 rtl/id_issue.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_issue.sv
// id_issue: RV32I decode, operand forwarding and issue into the ID/EX latch.
// Load-use hazards hold the instruction at the input and insert bubbles.
module id_issue #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int OPT_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  output logic                    in_ready,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  input  logic [XLEN-1:0]         r1_data,
  input  logic [XLEN-1:0]         r2_data,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_load,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_vd,
  input  logic                    ex_stall,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_pc,
  output logic [OPT_W-1:0]        out_op,
  output logic [XLEN-1:0]         out_vs1,
  output logic [XLEN-1:0]         out_vs2,
  output logic [4:0]              out_rd,
  output logic [XLEN-1:0]         out_imm,
  output logic                    out_we,
  output logic                    out_illegal,
  output logic [31:0]             stall_cnt
);

  localparam logic [OPT_W-1:0] ZeroOpt  = OPT_W'(0);
  localparam logic [OPT_W-1:0] OP_LUI   = OPT_W'(1);
  localparam logic [OPT_W-1:0] OP_AUIPC = OPT_W'(2);
  localparam logic [OPT_W-1:0] OP_JAL   = OPT_W'(3);
  localparam logic [OPT_W-1:0] OP_JALR  = OPT_W'(4);
  localparam logic [OPT_W-1:0] OP_BEQ   = OPT_W'(5);
  localparam logic [OPT_W-1:0] OP_BNE   = OPT_W'(6);
  localparam logic [OPT_W-1:0] OP_BLT   = OPT_W'(7);
  localparam logic [OPT_W-1:0] OP_BGE   = OPT_W'(8);
  localparam logic [OPT_W-1:0] OP_BLTU  = OPT_W'(9);
  localparam logic [OPT_W-1:0] OP_BGEU  = OPT_W'(10);
  localparam logic [OPT_W-1:0] OP_LB    = OPT_W'(11);
  localparam logic [OPT_W-1:0] OP_LH    = OPT_W'(12);
  localparam logic [OPT_W-1:0] OP_LW    = OPT_W'(13);
  localparam logic [OPT_W-1:0] OP_LBU   = OPT_W'(14);
  localparam logic [OPT_W-1:0] OP_LHU   = OPT_W'(15);
  localparam logic [OPT_W-1:0] OP_SB    = OPT_W'(16);
  localparam logic [OPT_W-1:0] OP_SH    = OPT_W'(17);
  localparam logic [OPT_W-1:0] OP_SW    = OPT_W'(18);
  localparam logic [OPT_W-1:0] OP_ADDI  = OPT_W'(19);
  localparam logic [OPT_W-1:0] OP_SLTI  = OPT_W'(20);
  localparam logic [OPT_W-1:0] OP_SLTIU = OPT_W'(21);
  localparam logic [OPT_W-1:0] OP_XORI  = OPT_W'(22);
  localparam logic [OPT_W-1:0] OP_ORI   = OPT_W'(23);
  localparam logic [OPT_W-1:0] OP_ANDI  = OPT_W'(24);
  localparam logic [OPT_W-1:0] OP_SLLI  = OPT_W'(25);
  localparam logic [OPT_W-1:0] OP_SRLI  = OPT_W'(26);
  localparam logic [OPT_W-1:0] OP_SRAI  = OPT_W'(27);
  localparam logic [OPT_W-1:0] OP_ADD   = OPT_W'(28);
  localparam logic [OPT_W-1:0] OP_SUB   = OPT_W'(29);
  localparam logic [OPT_W-1:0] OP_SLL   = OPT_W'(30);
  localparam logic [OPT_W-1:0] OP_SLT   = OPT_W'(31);
  localparam logic [OPT_W-1:0] OP_SLTU  = OPT_W'(32);
  localparam logic [OPT_W-1:0] OP_XOR   = OPT_W'(33);
  localparam logic [OPT_W-1:0] OP_SRL   = OPT_W'(34);
  localparam logic [OPT_W-1:0] OP_SRA   = OPT_W'(35);
  localparam logic [OPT_W-1:0] OP_OR    = OPT_W'(36);
  localparam logic [OPT_W-1:0] OP_AND   = OPT_W'(37);

  typedef enum logic [2:0] {
    K_X, K_R, K_I, K_S, K_B, K_U, K_J
  } kind_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [OPT_W-1:0] op;
    logic [XLEN-1:0]  vs1;
    logic [XLEN-1:0]  vs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  imm;
    logic             we;
    logic             ill;
  } lat_t;

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [OPT_W-1:0] w_op;
  kind_e            w_kind;
  logic [31:0]      w_ii, w_is, w_ib, w_iu, w_ij;
  logic             w_use1, w_use2;
  logic [XLEN-1:0]  w_v1, w_v2;
  logic             w_ld1, w_ld2;
  logic             w_haz, w_adv, w_xfer;
  lat_t             w_dec;
  lat_t             r_lat;
  logic             r_valid;
  logic [31:0]      r_cnt;

  assign w_opc = in_inst[6:0];
  assign w_f3  = in_inst[14:12];
  assign w_f7  = in_inst[31:25];
  assign rs1   = in_inst[19:15];
  assign rs2   = in_inst[24:20];

  assign w_ii = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_is = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_ib = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_iu = {in_inst[31:12], 12'b0};
  assign w_ij = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    w_op   = ZeroOpt;
    w_kind = K_X;
    case (w_opc)
      7'h37: begin w_op = OP_LUI;   w_kind = K_U; end
      7'h17: begin w_op = OP_AUIPC; w_kind = K_U; end
      7'h6f: begin w_op = OP_JAL;   w_kind = K_J; end
      7'h67: begin
        w_kind = K_I;
        if (w_f3 == 3'd0) w_op = OP_JALR;
      end
      7'h63: begin
        w_kind = K_B;
        case (w_f3)
          3'd0:    w_op = OP_BEQ;
          3'd1:    w_op = OP_BNE;
          3'd4:    w_op = OP_BLT;
          3'd5:    w_op = OP_BGE;
          3'd6:    w_op = OP_BLTU;
          3'd7:    w_op = OP_BGEU;
          default: w_op = ZeroOpt;
        endcase
      end
      7'h03: begin
        w_kind = K_I;
        case (w_f3)
          3'd0:    w_op = OP_LB;
          3'd1:    w_op = OP_LH;
          3'd2:    w_op = OP_LW;
          3'd4:    w_op = OP_LBU;
          3'd5:    w_op = OP_LHU;
          default: w_op = ZeroOpt;
        endcase
      end
      7'h23: begin
        w_kind = K_S;
        case (w_f3)
          3'd0:    w_op = OP_SB;
          3'd1:    w_op = OP_SH;
          3'd2:    w_op = OP_SW;
          default: w_op = ZeroOpt;
        endcase
      end
      7'h13: begin
        w_kind = K_I;
        case (w_f3)
          3'd0: w_op = OP_ADDI;
          3'd2: w_op = OP_SLTI;
          3'd3: w_op = OP_SLTIU;
          3'd4: w_op = OP_XORI;
          3'd6: w_op = OP_ORI;
          3'd7: w_op = OP_ANDI;
          3'd1: if (w_f7 == 7'h00) w_op = OP_SLLI;
          3'd5: begin
            if (w_f7 == 7'h00)      w_op = OP_SRLI;
            else if (w_f7 == 7'h20) w_op = OP_SRAI;
          end
          default: w_op = ZeroOpt;
        endcase
      end
      7'h33: begin
        w_kind = K_R;
        case ({w_f7, w_f3})
          {7'h00, 3'd0}: w_op = OP_ADD;
          {7'h20, 3'd0}: w_op = OP_SUB;
          {7'h00, 3'd1}: w_op = OP_SLL;
          {7'h00, 3'd2}: w_op = OP_SLT;
          {7'h00, 3'd3}: w_op = OP_SLTU;
          {7'h00, 3'd4}: w_op = OP_XOR;
          {7'h00, 3'd5}: w_op = OP_SRL;
          {7'h20, 3'd5}: w_op = OP_SRA;
          {7'h00, 3'd6}: w_op = OP_OR;
          {7'h00, 3'd7}: w_op = OP_AND;
          default:       w_op = ZeroOpt;
        endcase
      end
      default: w_op = ZeroOpt;
    endcase
    if (w_op == ZeroOpt) w_kind = K_X;
  end

  assign w_use1 = (w_kind == K_R) || (w_kind == K_I) ||
                  (w_kind == K_S) || (w_kind == K_B);
  assign w_use2 = (w_kind == K_R) || (w_kind == K_S) ||
                  (w_kind == K_B);

  // Scan high to low so the lowest (youngest) matching channel wins.
  always_comb begin
    w_v1  = r1_data;
    w_v2  = r2_data;
    w_ld1 = 1'b0;
    w_ld2 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_rd[i*5 +: 5] == rs1) begin
        w_v1  = fwd_vd[i*XLEN +: XLEN];
        w_ld1 = fwd_load[i];
      end
      if (fwd_we[i] && fwd_rd[i*5 +: 5] == rs2) begin
        w_v2  = fwd_vd[i*XLEN +: XLEN];
        w_ld2 = fwd_load[i];
      end
    end
    if (!w_use1 || rs1 == 5'd0) begin
      w_v1  = '0;
      w_ld1 = 1'b0;
    end
    if (!w_use2 || rs2 == 5'd0) begin
      w_v2  = '0;
      w_ld2 = 1'b0;
    end
  end

  always_comb begin
    w_dec     = '0;
    w_dec.pc  = in_pc;
    w_dec.op  = w_op;
    w_dec.ill = (w_kind == K_X);
    w_dec.vs1 = w_v1;
    w_dec.vs2 = w_v2;
    case (w_kind)
      K_R: w_dec.rd = in_inst[11:7];
      K_I: begin
        w_dec.rd  = in_inst[11:7];
        w_dec.imm = XLEN'($signed(w_ii));
      end
      K_S: w_dec.imm = XLEN'($signed(w_is));
      K_B: w_dec.imm = XLEN'($signed(w_ib));
      K_U: begin
        w_dec.rd  = in_inst[11:7];
        w_dec.imm = XLEN'($signed(w_iu));
      end
      K_J: begin
        w_dec.rd  = in_inst[11:7];
        w_dec.imm = XLEN'($signed(w_ij));
      end
      default: w_dec.rd = 5'd0;
    endcase
    w_dec.we = (w_dec.rd != 5'd0);
  end

  assign w_haz    = in_valid & (w_ld1 | w_ld2);
  assign w_adv    = rdy & ~ex_stall;
  assign in_ready = w_adv & ~w_haz & ~flush & ~rst;
  assign w_xfer   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_lat   <= '0;
      r_cnt   <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_valid <= 1'b0;
        r_lat   <= '0;
      end else if (!ex_stall) begin
        r_valid <= w_xfer;
        r_lat   <= w_xfer ? w_dec : '0;
      end
      if (w_haz && !flush && !ex_stall && r_cnt != '1)
        r_cnt <= r_cnt + 32'd1;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_lat.pc;
  assign out_op      = r_lat.op;
  assign out_vs1     = r_lat.vs1;
  assign out_vs2     = r_lat.vs2;
  assign out_rd      = r_lat.rd;
  assign out_imm     = r_lat.imm;
  assign out_we      = r_lat.we;
  assign out_illegal = r_lat.ill;
  assign stall_cnt   = r_cnt;

endmodule
